// File: rtl/bus_datapath_seq.sv
// Single-bus datapath: register file, HI/LO, Y, Z, MAR/MDR around one shared
// bus, sequenced by an internal micro-step FSM with a memory req/ack handshake.
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [IDX_W-1:0]  ra,
  input  logic [IDX_W-1:0]  rb,
  input  logic [IDX_W-1:0]  rc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] bus_contents,
  input  logic [IDX_W:0]    dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_SHL = 4'd4, OP_SHR = 4'd5, OP_NEG = 4'd6, OP_NOT = 4'd7,
                         OP_MUL = 4'd8, OP_LOAD = 4'd9, OP_STORE = 4'd10;

  localparam logic [3:0] S_IDLE = 4'd0, S_Y = 4'd1, S_Z = 4'd2, S_WB = 4'd3,
                         S_LO = 4'd4, S_HI = 4'd5, S_MAR = 4'd6, S_MDW = 4'd7,
                         S_WAIT = 4'd8, S_MDR = 4'd9;

  localparam logic [IDX_W:0] SEL_LO = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W:0] SEL_HI = (IDX_W+1)'(NUM_REGS + 1);

  // ALU: returns {Zhigh, Zlow}; Zhigh is only non-zero for the signed multiply
  function automatic logic [2*DATA_W-1:0] alu_f(input logic [3:0] opc,
                                                input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ax;
    logic signed [2*DATA_W-1:0] bx;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    hi = '0;
    case (opc)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_SHL:  lo = a << b[SH_W-1:0];
      OP_SHR:  lo = a >> b[SH_W-1:0];
      OP_NEG:  lo = -b;
      OP_NOT:  lo = ~b;
      OP_MUL:  {hi, lo} = ax * bx;
      default: lo = '0;
    endcase
    return {hi, lo};
  endfunction

  logic [3:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [IDX_W-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic              done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] y_q, y_d, zl_q, zl_d, zh_q, zh_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] bus;
  logic [2*DATA_W-1:0] alu_res;

  // Bus source selection: each micro-step names exactly one driver
  always_comb begin
    bus = '0;
    case (state_q)
      S_Y, S_MAR:  bus = regs_q[rb_q];
      S_Z, S_MDW:  bus = regs_q[rc_q];
      S_WB, S_LO:  bus = zl_q;
      S_HI:        bus = zh_q;
      S_MDR:       bus = mdr_q;
      default:     bus = '0;
    endcase
  end

  assign alu_res = alu_f(op_q, y_q, bus);

  // Sequencer and register-transfer next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    regs_d  = regs_q;
    y_d     = y_q;
    zl_d    = zl_q;
    zh_d    = zh_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          ra_d = ra;
          rb_d = rb;
          rc_d = rc;
          if (op <= OP_MUL) begin
            state_d = S_Y;
          end else if (op <= OP_STORE) begin
            state_d = S_MAR;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_Y: begin
        y_d     = bus;
        state_d = S_Z;
      end
      S_Z: begin
        {zh_d, zl_d} = alu_res;
        state_d      = (op_q == OP_MUL) ? S_LO : S_WB;
      end
      S_WB: begin
        regs_d[ra_q] = bus;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      S_LO: begin
        lo_d    = bus;
        state_d = S_HI;
      end
      S_HI: begin
        hi_d    = bus;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_MAR: begin
        mar_d   = bus;
        state_d = (op_q == OP_STORE) ? S_MDW : S_WAIT;
      end
      S_MDW: begin
        mdr_d   = bus;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_MDR;
          end
        end
      end
      S_MDR: begin
        regs_d[ra_q] = bus;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath registers and completion pulses
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      y_q     <= '0;
      zl_q    <= '0;
      zh_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
      y_q     <= y_d;
      zl_q    <= zl_d;
      zh_q    <= zh_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Debug read port: general registers, then LO, then HI, else zero
  always_comb begin
    dbg_data = '0;
    if (dbg_sel < SEL_LO)       dbg_data = regs_q[dbg_sel[IDX_W-1:0]];
    else if (dbg_sel == SEL_LO) dbg_data = lo_q;
    else if (dbg_sel == SEL_HI) dbg_data = hi_q;
  end

  // mem_req decodes straight from state so an async clear drops it at once
  assign mem_req      = (state_q == S_WAIT);
  assign mem_we       = (state_q == S_WAIT) && (op_q == OP_STORE);
  assign mem_addr     = mar_q;
  assign mem_wdata    = mdr_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign bus_contents = bus;

endmodule
